// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Optional feature: DEMUX_STATS_EN adds per-output transfer counters.
package demux_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  function automatic logic sel_legal(
    input logic [31:0] sel,
    input int unsigned n
  );
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register with EMPTY/FULL state.
// DEMUX_STATS_EN adds a saturating delivered-word counter.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] q,
  output logic              full
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  count
`endif
);

  slot_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      q     <= '0;
    end else begin
      case (state)
        EMPTY:   if (load) state <= FULL;
        FULL:    if (!load && ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      // old word leaves in the same edge a new one arrives
      if (load) q <= data;
    end
  end

  assign full  = (state == FULL);
  assign valid = full;

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (valid && ready && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/stream_demux.sv
// 1-to-N registered stream demux with per-output holding slots.
// Optional feature: DEMUX_STATS_EN adds the out_count port.
module stream_demux
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 2,
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    drop_err
`ifdef DEMUX_STATS_EN
  ,
  output logic [N_OUT*CNT_W-1:0]  out_count
`endif
);

  localparam int N_SEL = 2 ** SEL_W;

  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] load;
  logic [N_SEL-1:0] full_pad;
  logic [N_SEL-1:0] rdy_pad;
  logic             legal;
  logic             xfer;

  // pad to the full select range so an illegal index never reads out of bounds
  always_comb begin
    full_pad             = '0;
    rdy_pad              = '0;
    full_pad[N_OUT-1:0]  = full;
    rdy_pad[N_OUT-1:0]   = out_ready;
  end

  assign legal    = sel_legal(32'(in_sel), N_OUT);
  assign in_ready = !legal || !full_pad[in_sel] || rdy_pad[in_sel];
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if (xfer && !legal) begin
      drop_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign load[i] = xfer && legal && (in_sel == SEL_W'(i));

    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .data  (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .q     (out_data[i*DATA_W +: DATA_W]),
      .full  (full[i])
`ifdef DEMUX_STATS_EN
      ,
      .count (out_count[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Randomized scoreboard bench for stream_demux (N_OUT=3, SEL_W=2).
// Covers DEMUX_STATS_EN counters when that macro is defined.
module tb_stream_demux;

  localparam int DATA_W = 8;
  localparam int N_OUT  = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic                    drop_err;
`ifdef DEMUX_STATS_EN
  logic [N_OUT*16-1:0]     out_count;
  logic [15:0]             cnt_exp [N_OUT];
`endif

  stream_demux #(
    .DATA_W (DATA_W),
    .N_OUT  (N_OUT),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_err  (drop_err)
`ifdef DEMUX_STATS_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] exp_q [N_OUT][$];
  bit drop_exp;
  bit mon_en;
  bit rand_rdy;
  bit lg;
  bit exp_rdy;
  int waited;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_OUT; i++) begin
      exp_q[i].delete();
`ifdef DEMUX_STATS_EN
      cnt_exp[i] = '0;
`endif
    end
    drop_exp = 1'b0;
  endtask

  // Scoreboard: everything below fires at the coming rising edge
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      lg = (int'(in_sel) < N_OUT);
      exp_rdy = 1'b1;
      if (lg) exp_rdy = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("drop_err", 32'(drop_err), 32'(drop_exp));
      for (int i = 0; i < N_OUT; i++) begin
        check($sformatf("out_valid%0d", i), 32'(out_valid[i]),
              32'(exp_q[i].size() != 0));
`ifdef DEMUX_STATS_EN
        check($sformatf("out_count%0d", i), 32'(out_count[i*16 +: 16]),
              32'(cnt_exp[i]));
`endif
        if (exp_q[i].size() != 0) begin
          check($sformatf("out_data%0d", i),
                32'(out_data[i*DATA_W +: DATA_W]), 32'(exp_q[i][0]));
          if (out_ready[i]) begin
            void'(exp_q[i].pop_front());
`ifdef DEMUX_STATS_EN
            if (cnt_exp[i] != 16'hFFFF) cnt_exp[i]++;
`endif
          end
        end
      end
      if (in_valid && in_ready) begin
        if (lg) exp_q[in_sel].push_back(in_data);
        else drop_exp = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = N_OUT'($urandom);
  endtask

  // Present one word and hold it until accepted; waited = stall cycles
  task automatic send(input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    waited   = 0;
    acc      = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          check("send_timeout", 32'(waited), 32'd0);
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    mon_en    = 1'b0;
    rand_rdy  = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_sel    = 2'd1;
    out_ready = '1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    mon_en   = 1'b1;
    tick();

    // single word to output 1
    send(8'hA5, 2'd1);
    check("single_valid", 32'(out_valid), 32'b010);
    check("single_data", 32'(out_data[15:8]), 32'hA5);
    tick();
    tick();

    // backpressure on output 0
    out_ready = 3'b110;
    send(8'h11, 2'd0);
    in_valid = 1'b1;
    in_data  = 8'h22;
    in_sel   = 2'd0;
    tick();
    tick();
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold", 32'(out_data[7:0]), 32'h11);
    out_ready = 3'b111;
    send(8'h22, 2'd0);
    tick();
    tick();

    // independence: output 0 stalled and full
    out_ready = 3'b000;
    send(8'h55, 2'd0);
    send(8'h33, 2'd1);
    check("indep_wait", 32'(waited), 32'd0);
    check("indep_valid", 32'(out_valid), 32'b011);
    out_ready = 3'b111;
    tick();
    tick();

    // back-to-back words to output 0
    for (int k = 0; k < 4; k++) begin
      send(8'hC0 + 8'(k), 2'd0);
      check("b2b_wait", 32'(waited), 32'd0);
    end
    tick();
    tick();

    // illegal select is consumed and flagged
    out_ready = 3'b000;
    send(8'h77, 2'd3);
    check("drop_wait", 32'(waited), 32'd0);
    check("drop_set", 32'(drop_err), 32'd1);
    check("drop_no_valid", 32'(out_valid), 32'd0);
    tick();

    // reset mid-operation with a full slot
    send(8'h99, 2'd2);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_drop", 32'(drop_err), 32'd0);
    clear_model();
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(8'($urandom), ($urandom_range(0, 15) == 0) ? 2'd3
                         : 2'($urandom_range(0, N_OUT - 1)));
    end
    rand_rdy  = 1'b0;
    out_ready = '1;
    repeat (4) tick();
    check("drained", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()),
          32'd0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
